// File: rtl/cnu_row_sched.sv
// Row scheduler for the shared check-node min-finder tree: read row, pulse tree,
// capture min/min2/idx, offer downstream, repeat over all rows and iterations.
module cnu_row_sched #(
  parameter int unsigned DATA_W   = 9,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned N_ROWS   = 4,
  parameter int unsigned ROW_W    = 2,
  parameter int unsigned MAX_ITER = 10,
  parameter int unsigned ITER_W   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_halt,
  output logic              o_mem_rd_en,
  output logic [ROW_W-1:0]  o_mem_addr,
  output logic              o_tree_en,
  input  logic [DATA_W-1:0] i_tree_min,
  input  logic [DATA_W-1:0] i_tree_min2,
  input  logic [IDX_W-1:0]  i_tree_idx,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [DATA_W-1:0] o_res_min,
  output logic [DATA_W-1:0] o_res_min2,
  output logic [IDX_W-1:0]  o_res_idx,
  output logic [ROW_W-1:0]  o_res_row,
  output logic [ITER_W-1:0] o_res_iter,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(N_ROWS - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_EN   = 3'd2,
    S_CAP  = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ROW_W-1:0]    r_row;
  logic [ROW_W-1:0]    w_row_nxt;
  logic [ITER_W-1:0]   r_iter;
  logic [ITER_W-1:0]   w_iter_nxt;
  logic                r_stop_flag;
  logic                w_stop_nxt;
  logic                w_cap;

  logic                r_mem_rd_en;
  logic [ROW_W-1:0]    r_mem_addr;
  logic                r_tree_en;
  logic                r_res_valid;
  logic [DATA_W-1:0]   r_res_min;
  logic [DATA_W-1:0]   r_res_min2;
  logic [IDX_W-1:0]    r_res_idx;
  logic [ROW_W-1:0]    r_res_row;
  logic [ITER_W-1:0]   r_res_iter;
  logic                r_busy;
  logic                r_done;

  // Next-state, counter and stop-flag logic; halt overrides every busy state.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_iter_nxt  = r_iter;
    w_stop_nxt  = r_stop_flag | (i_stop & (r_state != S_IDLE));
    w_cap       = 1'b0;

    if ((r_state != S_IDLE) && i_halt) begin
      w_state_nxt = S_IDLE;
      w_row_nxt   = '0;
      w_iter_nxt  = '0;
      w_stop_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_halt) begin
            w_state_nxt = S_RD;
            w_row_nxt   = '0;
            w_iter_nxt  = '0;
            w_stop_nxt  = i_stop;
          end
        end
        S_RD:  w_state_nxt = S_EN;
        S_EN:  w_state_nxt = S_CAP;
        S_CAP: begin
          w_state_nxt = S_OUT;
          w_cap       = 1'b1;
        end
        S_OUT: begin
          if (i_res_ready) begin
            if (r_row != LAST_ROW) begin
              w_row_nxt   = r_row + ROW_W'(1);
              w_state_nxt = S_RD;
            end else begin
              w_row_nxt = '0;
              // Early termination is only honoured at an iteration boundary.
              if ((r_iter == LAST_ITER) || r_stop_flag || i_stop) begin
                w_state_nxt = S_DONE;
              end else begin
                w_iter_nxt  = r_iter + ITER_W'(1);
                w_state_nxt = S_RD;
              end
            end
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_iter      <= '0;
      r_stop_flag <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_iter      <= w_iter_nxt;
      r_stop_flag <= w_stop_nxt;
    end
  end

  // Strobes decoded from the next state so they are registered yet aligned with the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;
      r_tree_en   <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_mem_rd_en <= (w_state_nxt == S_RD);
      r_mem_addr  <= w_row_nxt;
      r_tree_en   <= (w_state_nxt == S_EN);
      r_res_valid <= (w_state_nxt == S_OUT);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  // Result payload holds until the next capture; only reset clears it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_res_min  <= '0;
      r_res_min2 <= '0;
      r_res_idx  <= '0;
      r_res_row  <= '0;
      r_res_iter <= '0;
    end else if (w_cap) begin
      r_res_min  <= i_tree_min;
      r_res_min2 <= i_tree_min2;
      r_res_idx  <= i_tree_idx;
      r_res_row  <= r_row;
      r_res_iter <= r_iter;
    end
  end

  assign o_mem_rd_en = r_mem_rd_en;
  assign o_mem_addr  = r_mem_addr;
  assign o_tree_en   = r_tree_en;
  assign o_res_valid = r_res_valid;
  assign o_res_min   = r_res_min;
  assign o_res_min2  = r_res_min2;
  assign o_res_idx   = r_res_idx;
  assign o_res_row   = r_res_row;
  assign o_res_iter  = r_res_iter;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_cnu_row_sched.sv
// Randomized bench for cnu_row_sched with a RAM/tree model and a result-sequence reference.
module tb_cnu_row_sched;
  localparam int unsigned DATA_W   = 9;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned N_ROWS   = 4;
  localparam int unsigned ROW_W    = 2;
  localparam int unsigned MAX_ITER = 2;
  localparam int unsigned ITER_W   = 4;
  localparam int unsigned RW       = ROW_W + ITER_W + 2*DATA_W + IDX_W;
  localparam int unsigned OW       = 5 + ROW_W + 2*DATA_W + IDX_W + ROW_W + ITER_W;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0, halt = 1'b0, res_ready = 1'b0;
  logic mem_rd_en, tree_en, res_valid, busy, done;
  logic [ROW_W-1:0]  mem_addr, res_row;
  logic [ITER_W-1:0] res_iter;
  logic [DATA_W-1:0] tree_min = '0, tree_min2 = '0, res_min, res_min2;
  logic [IDX_W-1:0]  tree_idx = '0, res_idx;

  logic [DATA_W-1:0] tv_min [N_ROWS];
  logic [DATA_W-1:0] tv_min2[N_ROWS];
  logic [IDX_W-1:0]  tv_idx [N_ROWS];
  logic [ROW_W-1:0]  ram_q = '0;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  cnu_row_sched #(
    .DATA_W(DATA_W), .IDX_W(IDX_W), .N_ROWS(N_ROWS), .ROW_W(ROW_W),
    .MAX_ITER(MAX_ITER), .ITER_W(ITER_W)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_halt(halt),
    .o_mem_rd_en(mem_rd_en), .o_mem_addr(mem_addr), .o_tree_en(tree_en),
    .i_tree_min(tree_min), .i_tree_min2(tree_min2), .i_tree_idx(tree_idx),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_min(res_min), .o_res_min2(res_min2), .o_res_idx(res_idx),
    .o_res_row(res_row), .o_res_iter(res_iter), .o_busy(busy), .o_done(done)
  );

  // Message RAM (1-cycle read) feeding a 1-cycle registered min-finder tree.
  always @(posedge clk) begin
    if (mem_rd_en) ram_q <= mem_addr;
    if (tree_en) begin
      tree_min  <= tv_min[ram_q];
      tree_min2 <= tv_min2[ram_q];
      tree_idx  <= tv_idx[ram_q];
    end
  end

  function automatic logic [RW-1:0] exp_res(input int k);
    int r;
    r = k % N_ROWS;
    return {ROW_W'(r), ITER_W'(k / N_ROWS), tv_min[r], tv_min2[r], tv_idx[r]};
  endfunction

  function automatic logic [OW-1:0] all_outs();
    return {mem_rd_en, tree_en, res_valid, busy, done, mem_addr,
            res_min, res_min2, res_idx, res_row, res_iter};
  endfunction

  task automatic rand_tv();
    for (int r = 0; r < N_ROWS; r++) begin
      tv_min[r]  = DATA_W'($urandom);
      tv_min2[r] = DATA_W'($urandom);
      tv_idx[r]  = IDX_W'($urandom);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Runs one decode from IDLE and checks the result stream against the reference sequence.
  task automatic run_check(input string name, input int ready_pct, input int stop_at, input bit poke);
    int k = 0, cyc, done_cyc = -1, n_done = 0, last_hs = -1;
    int rd_n = 0, en_n = 0, viol = 0, spacing_err = 0, exp_n;
    bit seen = 1'b0;
    logic [RW-1:0] got, want;
    rand_tv();
    exp_n = (stop_at >= 0) ? int'(N_ROWS) * (stop_at / int'(N_ROWS) + 1) : int'(N_ROWS * MAX_ITER);
    if (exp_n > int'(N_ROWS * MAX_ITER)) exp_n = int'(N_ROWS * MAX_ITER);
    start = 1'b1;
    step();
    cyc = 1;
    start = 1'b0;
    n_chk++;
    if ({busy, mem_rd_en, mem_addr} !== {2'b11, ROW_W'(0)})
      $display("FAIL %s first_read: got %b want %b", name, {busy, mem_rd_en, mem_addr}, {2'b11, ROW_W'(0)});
    else n_pass++;
    while (cyc < 2000) begin
      if (mem_rd_en === 1'b1) rd_n++;
      if (tree_en === 1'b1) en_n++;
      if (mem_rd_en === 1'b1 && tree_en === 1'b1) viol++;
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc > done_cyc) break;
      stop = 1'b0;
      if (res_valid === 1'b1) begin
        got  = {res_row, res_iter, res_min, res_min2, res_idx};
        want = exp_res(k);
        if (!seen) begin
          seen = 1'b1;
          n_chk++;
          if (got !== want) $display("FAIL %s result%0d: got %h want %h", name, k, got, want);
          else n_pass++;
          if (ready_pct == 100 && cyc != 4 + 4*k) spacing_err++;
          if (k == stop_at) stop = 1'b1;
        end
        res_ready = ($urandom_range(99) < ready_pct);
        if (res_ready) begin
          n_chk++;
          if (got !== want) $display("FAIL %s hold%0d: got %h want %h", name, k, got, want);
          else n_pass++;
          seen = 1'b0;
          k++;
          last_hs = cyc;
        end
      end else begin
        res_ready = ($urandom_range(99) < ready_pct);
      end
      if (poke) start = (busy === 1'b1) ? 1'($urandom_range(1)) : 1'b0;
      step();
      cyc++;
    end
    start = 1'b0;
    stop  = 1'b0;
    n_chk++;
    if (k !== exp_n) $display("FAIL %s result_count: got %0d want %0d", name, k, exp_n); else n_pass++;
    n_chk++;
    if (n_done !== 1) $display("FAIL %s done_pulses: got %0d want 1", name, n_done); else n_pass++;
    n_chk++;
    if (done_cyc !== last_hs + 1) $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, last_hs + 1);
    else n_pass++;
    n_chk++;
    if ({rd_n, en_n} !== {exp_n, exp_n}) $display("FAIL %s rd_en_counts: got %0d/%0d want %0d", name, rd_n, en_n, exp_n);
    else n_pass++;
    n_chk++;
    if ({viol, spacing_err} !== 64'd0) $display("FAIL %s overlap_spacing: got %0d/%0d want 0/0", name, viol, spacing_err);
    else n_pass++;
    if (ready_pct == 100) begin
      n_chk++;
      if (done_cyc !== 4*exp_n + 1) $display("FAIL %s done_latency: got %0d want %0d", name, done_cyc, 4*exp_n + 1);
      else n_pass++;
    end
    n_chk++;
    if ({busy, res_valid, done} !== 3'b000) $display("FAIL %s idle_after: got %b want 000", name, {busy, res_valid, done});
    else n_pass++;
  endtask

  task automatic test_reset();
    int t = 0;
    rand_tv();
    res_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (res_valid !== 1'b1 && t < 20) begin step(); t++; end
    n_chk++;
    if (res_valid !== 1'b1) $display("FAIL reset_reach_out: got %b want 1", res_valid); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (all_outs() !== '0) $display("FAIL reset_async_outs: got %h want 0", all_outs()); else n_pass++;
    #1 rst = 1'b0;
    step();
    n_chk++;
    if ({busy, mem_rd_en} !== 2'b00) $display("FAIL reset_idle: got %b want 00", {busy, mem_rd_en}); else n_pass++;
    run_check("post_reset", 100, -1, 1'b0);
  endtask

  task automatic test_full();
    run_check("full_run", 100, -1, 1'b0);
  endtask

  task automatic test_stall();
    int t = 0, errs = 0;
    logic [RW-1:0] want;
    rand_tv();
    tv_min[2] = 9'd5; tv_min2[2] = 9'd12; tv_idx[2] = 3'd6;
    want = {ROW_W'(2), ITER_W'(0), 9'd5, 9'd12, 3'd6};
    res_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    while (!(res_valid === 1'b1 && res_row === ROW_W'(2)) && t < 40) begin step(); t++; end
    res_ready = 1'b0;
    n_chk++;
    if ({res_row, res_iter, res_min, res_min2, res_idx} !== want)
      $display("FAIL stall_capture: got %h want %h", {res_row, res_iter, res_min, res_min2, res_idx}, want);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      step();
      if ({res_row, res_iter, res_min, res_min2, res_idx} !== want) errs++;
      if ({res_valid, mem_rd_en, tree_en} !== 3'b100) errs++;
    end
    n_chk++;
    if (errs !== 0) $display("FAIL stall_hold: got %0d deviations want 0", errs); else n_pass++;
    halt = 1'b1;
    step();
    halt = 1'b0;
    n_chk++;
    if ({busy, res_valid, done, res_min} !== {3'b000, 9'd5})
      $display("FAIL stall_halt_retain: got %h want %h", {busy, res_valid, done, res_min}, {3'b000, 9'd5});
    else n_pass++;
  endtask

  task automatic test_stop();
    run_check("stop_row1", 100, 1, 1'b0);
    run_check("stop_rand", 60, int'($urandom_range(N_ROWS*MAX_ITER - 1)), 1'b0);
  endtask

  task automatic test_halt();
    int t = 0, ens = 0, errs = 0;
    rand_tv();
    start = 1'b1; halt = 1'b1;
    step();
    start = 1'b0; halt = 1'b0;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL halt_beats_start: got %b want 0", busy); else n_pass++;
    res_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    while (t < 40) begin
      if (tree_en === 1'b1) begin
        if (ens == 2) break;
        ens++;
      end
      step();
      t++;
    end
    n_chk++;
    if ({ens, tree_en} !== {32'd2, 1'b1}) $display("FAIL halt_reach_en_row2: got %0d/%b want 2/1", ens, tree_en);
    else n_pass++;
    halt = 1'b1;
    step();
    halt = 1'b0;
    n_chk++;
    if ({busy, res_valid, done, mem_rd_en, tree_en} !== 5'b0)
      $display("FAIL halt_idle: got %b want 00000", {busy, res_valid, done, mem_rd_en, tree_en});
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      step();
      if ({busy, res_valid, done} !== 3'b000) errs++;
    end
    n_chk++;
    if (errs !== 0) $display("FAIL halt_quiet: got %0d deviations want 0", errs); else n_pass++;
    run_check("after_halt", 70, -1, 1'b0);
  endtask

  task automatic test_ignore();
    stop = 1'b1;
    repeat (3) step();
    stop = 1'b0;
    run_check("start_busy_stop_idle", 100, -1, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) run_check("random", 50, -1, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (all_outs() !== '0) $display("FAIL reset_outs: got %h want 0", all_outs()); else n_pass++;
    rst = 1'b0;
    step();
    test_reset();
    test_full();
    test_stall();
    test_stop();
    test_halt();
    test_ignore();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
